// File: rtl/switch_port.sv
// Memory-mapped switch input port: two-flop synchroniser, whole-word debounce,
// and a read-clear status word so software can poll for switch changes.
module switch_port #(
    parameter int WORD_W          = 8,
    parameter int OP_W            = 3,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int DATA_ADDR       = 2**(WORD_W-OP_W)-1,
    parameter int STAT_ADDR       = 2**(WORD_W-OP_W)-3
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [WORD_W-1:0]      switches,
    input  logic [WORD_W-OP_W-1:0] Daddress,
    input  logic                   RE,
    output logic [WORD_W-1:0]      Sdata,
    output logic [WORD_W-1:0]      io_rdata,
    output logic                   io_sel
);

    localparam int ADDR_W = WORD_W - OP_W;
    localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_SAT  = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [ADDR_W-1:0] DATA_A   = ADDR_W'(DATA_ADDR);
    localparam logic [ADDR_W-1:0] STAT_A   = ADDR_W'(STAT_ADDR);

    logic [WORD_W-1:0] sync1;
    logic [WORD_W-1:0] sync2;
    logic [WORD_W-1:0] candidate;
    logic [CNT_W-1:0]  count;
    logic              new_flag;
    logic              ovr_flag;

    logic              stable;
    logic              at_last;
    logic              commit;
    logic              is_data;
    logic              is_stat;
    logic              data_read;

    assign stable    = (sync2 == candidate);
    assign at_last   = (count == CNT_LAST);
    assign commit    = stable && at_last && (candidate != Sdata);
    assign is_data   = (Daddress == DATA_A);
    assign is_stat   = (Daddress == STAT_A);
    assign data_read = RE && is_data;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= switches;
            sync2 <= sync1;
        end
    end

    // Any bit change restarts the count; the commit happens once, on the edge
    // where the count reaches its last value, and the counter then saturates.
    always_ff @(posedge clock) begin
        if (reset) begin
            candidate <= '0;
            count     <= '0;
            Sdata     <= '0;
        end else if (!stable) begin
            candidate <= sync2;
            count     <= '0;
        end else if (at_last) begin
            count <= CNT_SAT;
            if (commit) begin
                Sdata <= candidate;
            end
        end else if (count < CNT_SAT) begin
            count <= count + 1'b1;
        end
    end

    // A commit landing on the same edge as a data read keeps new_flag set,
    // so the fresh value is still announced, but does not count as overrun.
    always_ff @(posedge clock) begin
        if (reset) begin
            new_flag <= 1'b0;
            ovr_flag <= 1'b0;
        end else begin
            if (commit) begin
                new_flag <= 1'b1;
            end else if (data_read) begin
                new_flag <= 1'b0;
            end

            if (commit && new_flag && !data_read) begin
                ovr_flag <= 1'b1;
            end else if (data_read) begin
                ovr_flag <= 1'b0;
            end
        end
    end

    always_comb begin
        io_rdata = '0;
        io_sel   = 1'b0;
        if (is_data) begin
            io_rdata = Sdata;
            io_sel   = 1'b1;
        end else if (is_stat) begin
            io_rdata = {{(WORD_W-2){1'b0}}, ovr_flag, new_flag};
            io_sel   = 1'b1;
        end
    end

endmodule

// File: tb/tb_switch_port.sv
// Directed bench for switch_port with a short debounce window, table-driven
// cycle vectors plus hand sequences for mid-debounce reset and address decode.
module tb_switch_port;

    localparam int WORD_W = 8;
    localparam int OP_W   = 3;
    localparam int DC     = 4;
    localparam int ADDR_W = WORD_W - OP_W;

    logic              clock;
    logic              reset;
    logic [WORD_W-1:0] switches;
    logic [ADDR_W-1:0] Daddress;
    logic              RE;
    logic [WORD_W-1:0] Sdata;
    logic [WORD_W-1:0] io_rdata;
    logic              io_sel;

    int checks;
    int failures;

    typedef struct {
        logic              rst;
        logic [WORD_W-1:0] sw;
        logic [ADDR_W-1:0] addr;
        logic              re;
        int                n;
        logic [WORD_W-1:0] exp_sdata;
        logic [WORD_W-1:0] exp_rdata;
        logic              exp_sel;
    } vec_t;

    localparam int NVEC = 22;
    vec_t vecs [NVEC];

    switch_port #(
        .WORD_W(WORD_W),
        .OP_W(OP_W),
        .DEBOUNCE_CYCLES(DC)
    ) dut (
        .clock(clock),
        .reset(reset),
        .switches(switches),
        .Daddress(Daddress),
        .RE(RE),
        .Sdata(Sdata),
        .io_rdata(io_rdata),
        .io_sel(io_sel)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic apply_stimulus(input logic rst, input logic [WORD_W-1:0] sw,
                                  input logic [ADDR_W-1:0] addr, input logic re);
        reset    = rst;
        switches = sw;
        Daddress = addr;
        RE       = re;
    endtask

    task automatic check_output(input string name, input logic [WORD_W-1:0] act,
                                input logic [WORD_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%02h, expected 0x%02h", name, act, exp);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        apply_stimulus(1'b1, 8'h00, 5'd29, 1'b0);

        // Rows: reset, switches, address, RE, edges, then Sdata/io_rdata/io_sel after them.
        vecs[0]  = '{1'b1, 8'hA5, 5'd29, 1'b0, 1,  8'h00, 8'h00, 1'b1};
        vecs[1]  = '{1'b1, 8'hA5, 5'd29, 1'b0, 2,  8'h00, 8'h00, 1'b1};
        vecs[2]  = '{1'b0, 8'hA5, 5'd29, 1'b0, 6,  8'h00, 8'h00, 1'b1};
        vecs[3]  = '{1'b0, 8'hA5, 5'd29, 1'b0, 1,  8'hA5, 8'h01, 1'b1};
        vecs[4]  = '{1'b0, 8'hA5, 5'd31, 1'b1, 1,  8'hA5, 8'hA5, 1'b1};
        vecs[5]  = '{1'b0, 8'hA5, 5'd29, 1'b0, 1,  8'hA5, 8'h00, 1'b1};
        vecs[6]  = '{1'b0, 8'h3C, 5'd29, 1'b0, 3,  8'hA5, 8'h00, 1'b1};
        vecs[7]  = '{1'b0, 8'hA5, 5'd29, 1'b0, 10, 8'hA5, 8'h00, 1'b1};
        vecs[8]  = '{1'b0, 8'h3C, 5'd29, 1'b0, 6,  8'hA5, 8'h00, 1'b1};
        vecs[9]  = '{1'b0, 8'h3C, 5'd29, 1'b0, 1,  8'h3C, 8'h01, 1'b1};
        vecs[10] = '{1'b0, 8'h3C, 5'd31, 1'b1, 1,  8'h3C, 8'h3C, 1'b1};
        vecs[11] = '{1'b0, 8'h3C, 5'd29, 1'b0, 1,  8'h3C, 8'h00, 1'b1};
        vecs[12] = '{1'b0, 8'h11, 5'd29, 1'b0, 7,  8'h11, 8'h01, 1'b1};
        vecs[13] = '{1'b0, 8'h22, 5'd29, 1'b0, 7,  8'h22, 8'h03, 1'b1};
        vecs[14] = '{1'b0, 8'h22, 5'd5,  1'b1, 1,  8'h22, 8'h00, 1'b0};
        vecs[15] = '{1'b0, 8'h22, 5'd29, 1'b0, 1,  8'h22, 8'h03, 1'b1};
        vecs[16] = '{1'b0, 8'h22, 5'd31, 1'b1, 1,  8'h22, 8'h22, 1'b1};
        vecs[17] = '{1'b0, 8'h22, 5'd29, 1'b0, 1,  8'h22, 8'h00, 1'b1};
        vecs[18] = '{1'b0, 8'h33, 5'd29, 1'b0, 7,  8'h33, 8'h01, 1'b1};
        vecs[19] = '{1'b0, 8'h7F, 5'd29, 1'b0, 6,  8'h33, 8'h01, 1'b1};
        vecs[20] = '{1'b0, 8'h7F, 5'd31, 1'b1, 1,  8'h7F, 8'h7F, 1'b1};
        vecs[21] = '{1'b0, 8'h7F, 5'd29, 1'b0, 1,  8'h7F, 8'h01, 1'b1};

        tick(1);
        for (int i = 0; i < NVEC; i++) begin
            apply_stimulus(vecs[i].rst, vecs[i].sw, vecs[i].addr, vecs[i].re);
            tick(vecs[i].n);
            check_output($sformatf("vec%0d Sdata", i), Sdata, vecs[i].exp_sdata);
            check_output($sformatf("vec%0d io_rdata", i), io_rdata, vecs[i].exp_rdata);
            check_output($sformatf("vec%0d io_sel", i), {7'd0, io_sel}, {7'd0, vecs[i].exp_sel});
        end

        // Reset in the middle of a debounce window drops the pending value.
        apply_stimulus(1'b0, 8'h55, 5'd29, 1'b0);
        tick(5);
        check_output("mid count", 8'(dut.count), 8'd2);
        check_output("mid candidate", dut.candidate, 8'h55);
        check_output("mid Sdata", Sdata, 8'h7F);
        apply_stimulus(1'b1, 8'h00, 5'd29, 1'b0);
        tick(1);
        check_output("rst count", 8'(dut.count), 8'd0);
        check_output("rst candidate", dut.candidate, 8'h00);
        check_output("rst Sdata", Sdata, 8'h00);
        check_output("rst status", io_rdata, 8'h00);
        apply_stimulus(1'b0, 8'h00, 5'd29, 1'b0);
        tick(12);
        check_output("post-rst Sdata", Sdata, 8'h00);
        check_output("post-rst status", io_rdata, 8'h00);

        // Decode is purely combinational and independent of RE.
        apply_stimulus(1'b0, 8'h00, 5'd31, 1'b0);
        #1;
        check_output("sel data no RE", {7'd0, io_sel}, 8'd1);
        apply_stimulus(1'b0, 8'h00, 5'd30, 1'b1);
        #1;
        check_output("sel addr30", {7'd0, io_sel}, 8'd0);
        check_output("rdata addr30", io_rdata, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
